alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`timescale 1ns / 1ps
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Requests are granted in IDLE (single valid requester wins, otherwise the
// priority pointer decides, then flips to the loser). The accepted op and
// operands are registered and drive the shared ALU. One cycle later (EXEC)
// the ALU result is captured; the response is then held (RESP) for the
// owning requester until it is taken.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   reqN_valid/ready            request handshake, N = 0, 1
//   reqN_op, reqN_a, reqN_b     op select and operands
//   rspN_valid/ready            response handshake
//   rspN_q, rspN_cmp            result value and compare flag
//   alu_s, alu_a, alu_b         to the shared ALU
//   alu_q, alu_cmp              from the shared ALU
module alu_arbiter #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_q,
    output logic        rsp0_cmp,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_q,
    output logic        rsp1_cmp,

    output logic [5:0]  alu_s,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_q,
    input  logic        alu_cmp
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q;
    logic        prio_q;      // requester that wins a tie
    logic        owner_q;     // requester owning the in-flight op
    logic [5:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] res_q;
    logic        cmp_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;

    logic        grant_any;
    logic        grant_id;
    logic        accept;
    logic        rsp_taken;

    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = prio_q;
        end else begin
            grant_id = req1_valid;
        end
        // Gated by rst_n so nothing is accepted while reset is held.
        accept     = rst_n && (state_q == StIdle) && grant_any;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        rsp_taken  = owner_q ? rsp1_ready : rsp0_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            prio_q       <= PRIO_INIT[0];
            owner_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            cmp_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= grant_id ? req1_op : req0_op;
                        a_q     <= grant_id ? req1_a  : req0_a;
                        b_q     <= grant_id ? req1_b  : req0_b;
                        owner_q <= grant_id;
                        prio_q  <= ~grant_id;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    res_q        <= alu_q;
                    cmp_q        <= alu_cmp;
                    rsp0_valid_q <= ~owner_q;
                    rsp1_valid_q <= owner_q;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (rsp_taken) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign alu_s      = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_q     = res_q;
    assign rsp1_q     = res_q;
    assign rsp0_cmp   = cmp_q;
    assign rsp1_cmp   = cmp_q;

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns / 1ps
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
module tb_alu_arbiter;

    localparam logic [5:0] ALU_ADD = 6'd0;
    localparam logic [5:0] ALU_SUB = 6'd1;
    localparam logic [5:0] ALU_LT  = 6'd2;
    localparam logic [5:0] ALU_LTU = 6'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [5:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_cmp;
    logic        rsp1_valid, rsp1_ready, rsp1_cmp;
    logic [31:0] rsp0_q, rsp1_q;
    logic [5:0]  alu_s;
    logic [31:0] alu_a, alu_b, alu_q;
    logic        alu_cmp;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_q     (rsp0_q),
        .rsp0_cmp   (rsp0_cmp),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_q     (rsp1_q),
        .rsp1_cmp   (rsp1_cmp),
        .alu_s      (alu_s),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_q      (alu_q),
        .alu_cmp    (alu_cmp)
    );

    // Shared ALU model.
    always_comb begin
        alu_q   = '0;
        alu_cmp = 1'b0;
        case (alu_s)
            ALU_ADD: alu_q = alu_a + alu_b;
            ALU_SUB: alu_q = alu_a - alu_b;
            ALU_LT: begin
                alu_cmp = ($signed(alu_a) < $signed(alu_b));
                alu_q   = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            end
            ALU_LTU: begin
                alu_cmp = (alu_a < alu_b);
                alu_q   = {31'd0, (alu_a < alu_b)};
            end
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_op    = '0;
        req1_op    = '0;
        req0_a     = '0;
        req0_b     = '0;
        req1_a     = '0;
        req1_b     = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        if (1) begin
            n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
            n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
            n_cmp++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp0_valid: got %b want 0", rsp0_valid); end
            n_cmp++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp1_valid: got %b want 0", rsp1_valid); end
            n_cmp++; if (alu_s !== 6'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin n_fail++; $display("FAIL reset_alu_bus: got s=%h a=%h b=%h want 0", alu_s, alu_a, alu_b); end
            n_cmp++; if (rsp0_q !== 32'd0 || rsp0_cmp !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_data: got q=%h cmp=%b want 0", rsp0_q, rsp0_cmp); end
        end
    endtask

    task automatic test_single();
        do_reset();
        req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %b want 1", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready1: got %b want 0", req1_ready); end
        step();
        n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready0_exec: got %b want 0", req0_ready); end
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp0_early: got %b want 0", rsp0_valid); end
        n_cmp++; if (alu_s !== ALU_ADD || alu_a !== 32'd5 || alu_b !== 32'd7) begin n_fail++; $display("FAIL single_alu_bus: got s=%h a=%h b=%h want 0/5/7", alu_s, alu_a, alu_b); end
        req0_valid = 1'b0;
        step();
        n_cmp++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp0_valid: got %b want 1", rsp0_valid); end
        n_cmp++; if (rsp0_q !== 32'd12) begin n_fail++; $display("FAIL single_rsp0_q: got %0d want 12", rsp0_q); end
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp1_valid: got %b want 0", rsp1_valid); end
        step();
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp0_done: got %b want 0", rsp0_valid); end
    endtask

    task automatic test_contention();
        logic        exp_id;
        logic [31:0] exp_q;
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id  = i[0];
            req0_op = ALU_ADD; req0_a = 32'(i + 1); req0_b = 32'd1;
            req1_op = ALU_SUB; req1_a = 32'd100;    req1_b = 32'(i);
            exp_q   = exp_id ? 32'(100 - i) : 32'(i + 2);
            #1;
            n_cmp++; if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin n_fail++; $display("FAIL contend_grant%0d: got r0=%b r1=%b want owner %0d", i, req0_ready, req1_ready, exp_id); end
            step();
            n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL contend_exec_ready%0d: got r0=%b r1=%b want 0", i, req0_ready, req1_ready); end
            step();
            n_cmp++; if (rsp0_valid !== ~exp_id || rsp1_valid !== exp_id) begin n_fail++; $display("FAIL contend_owner%0d: got v0=%b v1=%b want owner %0d", i, rsp0_valid, rsp1_valid, exp_id); end
            n_cmp++; if (rsp0_q !== exp_q) begin n_fail++; $display("FAIL contend_q%0d: got %0d want %0d", i, rsp0_q, exp_q); end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp1_ready = 1'b0;
        req1_op = ALU_SUB; req1_a = 32'd3; req1_b = 32'd10; req1_valid = 1'b1;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b want 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2; req0_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (rsp1_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp1_valid%0d: got %b want 1", i, rsp1_valid); end
            n_cmp++; if (rsp1_q !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL bp_rsp1_q%0d: got %h want fffffff9", i, rsp1_q); end
            n_cmp++; if (req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req0_blocked%0d: got ready=%b v0=%b want 0/0", i, req0_ready, rsp0_valid); end
            step();
        end
        rsp1_ready = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready0_at_hs: got %b want 0", req0_ready); end
        step();
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL bp_rsp1_done: got %b want 0", rsp1_valid); end
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0_after: got %b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        step();
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_q !== 32'd3) begin n_fail++; $display("FAIL bp_next_op: got v0=%b q=%0d want 1/3", rsp0_valid, rsp0_q); end
        step();
    endtask

    task automatic test_compare();
        do_reset();
        req0_op = ALU_LTU; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_cmp !== 1'b0) begin n_fail++; $display("FAIL cmp_ltu: got v=%b cmp=%b want 1/0", rsp0_valid, rsp0_cmp); end
        step();
        req0_op = ALU_LT; req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_cmp !== 1'b1) begin n_fail++; $display("FAIL cmp_lt: got v=%b cmp=%b want 1/1", rsp0_valid, rsp0_cmp); end
        n_cmp++; if (rsp1_cmp !== 1'b1) begin n_fail++; $display("FAIL cmp_lt_rsp1_bus: got %b want 1", rsp1_cmp); end
        step();
    endtask

    task automatic test_reset_exec();
        do_reset();
        req0_op = ALU_ADD; req0_a = 32'd4; req0_b = 32'd4; req0_valid = 1'b1;
        step();
        req1_op = ALU_SUB; req1_a = 32'd9; req1_b = 32'd1; req1_valid = 1'b1;
        rst_n = 1'b0;
        step();
        n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rexec_rsp_valid: got v0=%b v1=%b want 0", rsp0_valid, rsp1_valid); end
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rexec_ready_in_reset: got r0=%b r1=%b want 0", req0_ready, req1_ready); end
        n_cmp++; if (alu_s !== 6'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin n_fail++; $display("FAIL rexec_alu_bus: got s=%h a=%h b=%h want 0", alu_s, alu_a, alu_b); end
        n_cmp++; if (rsp0_q !== 32'd0 || rsp1_cmp !== 1'b0) begin n_fail++; $display("FAIL rexec_rsp_data: got q=%h cmp=%b want 0", rsp0_q, rsp1_cmp); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rexec_prio: got r0=%b r1=%b want 1/0", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rexec_no_stale_rsp: got %b want 0", rsp0_valid); end
        step();
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_q !== 32'd8) begin n_fail++; $display("FAIL rexec_new_op: got v0=%b q=%0d want 1/8", rsp0_valid, rsp0_q); end
        step();
    endtask

    task automatic test_idle();
        do_reset();
        req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        step();
        req1_op = ALU_ADD; req1_a = 32'd2; req1_b = 32'd2; req1_valid = 1'b1;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL idle_grant1: got %b want 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        step();
        n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_q !== 32'd4 || rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rsp1: got v1=%b q=%0d v0=%b want 1/4/0", rsp1_valid, rsp1_q, rsp0_valid); end
        step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL idle_quiet%0d: got r0=%b r1=%b v0=%b v1=%b want 0", i, req0_ready, req1_ready, rsp0_valid, rsp1_valid); end
            step();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL idle_next_grant: got r0=%b r1=%b want 1/0", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_q !== 32'd2) begin n_fail++; $display("FAIL idle_next_rsp: got v0=%b q=%0d want 1/2", rsp0_valid, rsp0_q); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_compare();
        test_reset_exec();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
